// File: rtl/pos_jogo_pkg.sv
// Board-wide constants shared by both player position controllers and the display.
// Defaults only; each instance may still override its own parameters.
package pos_jogo_pkg;
   localparam int N_POS           = 8;
   localparam int POS_INICIAL     = 3;
   localparam int DEBOUNCE_PADRAO = 4;
endpackage

// File: rtl/controle_posicao_jogador2_debounce_botao.sv
// One button: 2-flop synchroniser, stable-count debounce and rising-edge pulse.
// The pulse follows a clean input edge by DEBOUNCE_CYCLES+1 clocks; there is no backpressure.
module debounce_botao
   import pos_jogo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
   input  logic clk,
   input  logic rst,
   input  logic botao,
   output logic pulso
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sinc_a;
   logic          sinc;
   logic          deb;
   logic          deb_ant;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sinc_a  <= 1'b0;
         sinc    <= 1'b0;
         deb     <= 1'b0;
         deb_ant <= 1'b0;
         cnt     <= '0;
      end else begin
         sinc_a  <= botao;
         sinc    <= sinc_a;
         deb_ant <= deb;
         // Any sample agreeing with the accepted level restarts the stability count.
         if (sinc == deb) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb <= sinc;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign pulso = deb & ~deb_ant;
endmodule

// File: rtl/controle_posicao_jogador2.sv
// Player-2 position: debounced button presses step a saturating position counter.
// Position and strobes update DEBOUNCE_CYCLES+2 clocks after a clean press; no backpressure.
module controle_posicao_jogador2
   import pos_jogo_pkg::*;
#(
   parameter int N_POS           = pos_jogo_pkg::N_POS,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
   parameter int POS_INICIAL     = pos_jogo_pkg::POS_INICIAL
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       SinalBotao1,
   input  logic                       SinalBotao2,
   output logic [$clog2(N_POS)-1:0]   posicao,
   output logic [N_POS-1:0]           posicao_onehot,
   output logic                       movimento,
   output logic                       limite
);
   localparam int PW = $clog2(N_POS);
   localparam logic [N_POS-1:0] UM = N_POS'(1);

   logic          sobe;
   logic          desce;
   logic [PW-1:0] pos_prox;
   logic          mov_prox;
   logic          lim_prox;

   debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_botao_sobe (
      .clk   (clk),
      .rst   (rst),
      .botao (SinalBotao1),
      .pulso (sobe)
   );

   debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_botao_desce (
      .clk   (clk),
      .rst   (rst),
      .botao (SinalBotao2),
      .pulso (desce)
   );

   // Simultaneous requests cancel; bounds are checked before the add/subtract so nothing wraps.
   always_comb begin
      pos_prox = posicao;
      mov_prox = 1'b0;
      lim_prox = 1'b0;
      if (sobe && !desce) begin
         if (posicao == PW'(N_POS - 1)) begin
            lim_prox = 1'b1;
         end else begin
            pos_prox = posicao + PW'(1);
            mov_prox = 1'b1;
         end
      end else if (desce && !sobe) begin
         if (posicao == '0) begin
            lim_prox = 1'b1;
         end else begin
            pos_prox = posicao - PW'(1);
            mov_prox = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         posicao        <= PW'(POS_INICIAL);
         posicao_onehot <= UM << POS_INICIAL;
         movimento      <= 1'b0;
         limite         <= 1'b0;
      end else begin
         posicao        <= pos_prox;
         posicao_onehot <= UM << pos_prox;
         movimento      <= mov_prox;
         limite         <= lim_prox;
      end
   end
endmodule

// File: tb/tb_controle_posicao_jogador2.sv
// Bench for two instances: defaults (8 positions, 4-cycle debounce) and 5 positions, 1-cycle debounce.
module tb_controle_posicao_jogador2;
   logic       clk = 1'b0;
   logic       rst;
   logic       a1, a2, b1, b2;
   logic [2:0] pos_a, pos_b;
   logic [7:0] oh_a;
   logic [4:0] oh_b;
   logic       mov_a, lim_a, mov_b, lim_b;

   typedef struct {
      int         cyc;
      logic [2:0] pos;
      logic       mov;
      logic       lim;
   } ev_t;

   ev_t        qa[$];
   ev_t        qb[$];
   ev_t        ea, eb;
   int         cyc = 0;
   int         compared = 0;
   int         mism = 0;
   int         mpos_a, mpos_b;

   controle_posicao_jogador2 dut_a (
      .clk(clk), .rst(rst), .SinalBotao1(a1), .SinalBotao2(a2),
      .posicao(pos_a), .posicao_onehot(oh_a), .movimento(mov_a), .limite(lim_a)
   );

   controle_posicao_jogador2 #(.N_POS(5), .DEBOUNCE_CYCLES(1), .POS_INICIAL(3)) dut_b (
      .clk(clk), .rst(rst), .SinalBotao1(b1), .SinalBotao2(b2),
      .posicao(pos_b), .posicao_onehot(oh_b), .movimento(mov_b), .limite(lim_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called on the negedge where the button level is driven; the edge after it is edge k.
   task automatic expect_req(input int sel, input bit up);
      int  n, d, p;
      ev_t e;
      n = (sel == 0) ? 8 : 5;
      d = (sel == 0) ? 4 : 1;
      p = (sel == 0) ? mpos_a : mpos_b;
      e.cyc = cyc + 1 + d + 2;
      e.mov = 1'b0;
      e.lim = 1'b0;
      if (up) begin
         if (p < n - 1) begin p++; e.mov = 1'b1; end else e.lim = 1'b1;
      end else begin
         if (p > 0) begin p--; e.mov = 1'b1; end else e.lim = 1'b1;
      end
      e.pos = 3'(p);
      if (sel == 0) begin mpos_a = p; qa.push_back(e); end
      else begin mpos_b = p; qb.push_back(e); end
   endtask

   task automatic drive(input int sel, input bit up, input logic v);
      if (sel == 0) begin if (up) a1 = v; else a2 = v; end
      else begin if (up) b1 = v; else b2 = v; end
   endtask

   task automatic press(input int sel, input bit up, input int hold);
      @(negedge clk);
      drive(sel, up, 1'b1);
      expect_req(sel, up);
      repeat (hold) @(negedge clk);
      drive(sel, up, 1'b0);
      repeat (12) @(negedge clk);
      if (sel == 0) chk("a_pos_after_press", 32'(pos_a), 32'(mpos_a));
      else          chk("b_pos_after_press", 32'(pos_b), 32'(mpos_b));
   endtask

   task automatic sync_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mpos_a = 3;
      mpos_b = 3;
      chk("a_pos_reset", 32'(pos_a), 32'd3);
      chk("b_pos_reset", 32'(pos_b), 32'd3);
   endtask

   always @(negedge clk) begin
      if ((qa.size() > 0 && qa[0].cyc == cyc) || mov_a || lim_a) begin
         if (qa.size() == 0) begin
            chk("a_spurious_strobe", {30'd0, mov_a, lim_a}, 32'd0);
         end else begin
            ea = qa.pop_front();
            chk("a_event_edge", cyc, ea.cyc);
            chk("a_event_pos", 32'(pos_a), 32'(ea.pos));
            chk("a_event_onehot", 32'(oh_a), 32'(8'(1) << ea.pos));
            chk("a_event_mov", 32'(mov_a), 32'(ea.mov));
            chk("a_event_lim", 32'(lim_a), 32'(ea.lim));
         end
      end
   end

   always @(negedge clk) begin
      if ((qb.size() > 0 && qb[0].cyc == cyc) || mov_b || lim_b) begin
         if (qb.size() == 0) begin
            chk("b_spurious_strobe", {30'd0, mov_b, lim_b}, 32'd0);
         end else begin
            eb = qb.pop_front();
            chk("b_event_edge", cyc, eb.cyc);
            chk("b_event_pos", 32'(pos_b), 32'(eb.pos));
            chk("b_event_mov", 32'(mov_b), 32'(eb.mov));
            chk("b_event_lim", 32'(lim_b), 32'(eb.lim));
         end
      end
      if (!rst) chk("b_onehot_tracks_pos", 32'(oh_b), 32'(5'(1) << pos_b));
   end

   initial begin
      rst = 1'b1;
      a1 = 1'b0; a2 = 1'b0; b1 = 1'b0; b2 = 1'b0;
      mpos_a = 3;
      mpos_b = 3;
      repeat (2) @(negedge clk);
      chk("rst_pos_a", 32'(pos_a), 32'd3);
      chk("rst_onehot_a", 32'(oh_a), 32'h08);
      chk("rst_strobes_a", {30'd0, mov_a, lim_a}, 32'd0);
      chk("rst_onehot_b", 32'(oh_b), 32'h08);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Clean 20-cycle press, then held without further movement.
      press(0, 1'b1, 20);

      // Short glitch must be ignored.
      @(negedge clk); a1 = 1'b1;
      repeat (2) @(negedge clk); a1 = 1'b0;
      repeat (12) @(negedge clk);
      chk("a_pos_after_glitch", 32'(pos_a), 32'd4);

      // Bounce train 1-0-1-0 before settling high: one increment only.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); a1 = (i % 2 == 0);
      end
      @(negedge clk); a1 = 1'b1;
      expect_req(0, 1'b1);
      repeat (20) @(negedge clk); a1 = 1'b0;
      repeat (12) @(negedge clk);
      chk("a_pos_after_bounce", 32'(pos_a), 32'd5);

      // Saturation at both ends.
      sync_reset();
      for (int i = 0; i < 5; i++) press(0, 1'b1, 8);
      chk("a_pos_top_clamp", 32'(pos_a), 32'd7);
      for (int i = 0; i < 8; i++) press(0, 1'b0, 8);
      chk("a_pos_bottom_clamp", 32'(pos_a), 32'd0);

      // Simultaneous presses cancel; staggered presses both act.
      sync_reset();
      @(negedge clk); a1 = 1'b1; a2 = 1'b1;
      repeat (20) @(negedge clk); a1 = 1'b0; a2 = 1'b0;
      repeat (12) @(negedge clk);
      chk("a_pos_both_cancel", 32'(pos_a), 32'd3);
      @(negedge clk); a1 = 1'b1; expect_req(0, 1'b1);
      repeat (10) @(negedge clk); a2 = 1'b1; expect_req(0, 1'b0);
      repeat (20) @(negedge clk); a1 = 1'b0; a2 = 1'b0;
      repeat (12) @(negedge clk);
      chk("a_pos_staggered", 32'(pos_a), 32'd3);

      // Asynchronous reset mid-debounce, button kept held through release.
      for (int i = 0; i < 3; i++) press(0, 1'b1, 8);
      chk("a_pos_before_async_rst", 32'(pos_a), 32'd6);
      @(negedge clk); a2 = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("a_pos_async_rst", 32'(pos_a), 32'd3);
      chk("a_onehot_async_rst", 32'(oh_a), 32'h08);
      chk("a_strobes_async_rst", {30'd0, mov_a, lim_a}, 32'd0);
      mpos_a = 3;
      mpos_b = 3;
      @(negedge clk); rst = 1'b0; expect_req(0, 1'b0);
      repeat (20) @(negedge clk); a2 = 1'b0;
      repeat (12) @(negedge clk);
      chk("a_pos_after_held_release", 32'(pos_a), 32'd2);

      // Small instance sweep: 4-edge latency, clamps at 4 and 0.
      for (int i = 0; i < 3; i++) press(1, 1'b1, 4);
      chk("b_pos_top_clamp", 32'(pos_b), 32'd4);
      for (int i = 0; i < 6; i++) press(1, 1'b0, 4);
      chk("b_pos_bottom_clamp", 32'(pos_b), 32'd0);

      repeat (5) @(negedge clk);
      chk("a_events_pending", qa.size(), 32'd0);
      chk("b_events_pending", qb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end
endmodule

// File: doc/controle_posicao_jogador2.md
Name: controle_posicao_jogador2

Overview:
Consumer side of player-2's two button lines: turns raw, bouncing SinalBotao1/SinalBotao2 levels into a registered, bounded player position for the game core and LED row.
- Pipeline: synchronise, debounce, rising-edge detect, then a saturating position counter.
- Outputs: binary position, a one-hot copy for direct LED drive, and per-event strobes.
- Sits between the board push-buttons and the game logic and display.

Parameters:
N_POS, 8, number of legal positions (0..N_POS-1), N_POS >= 2
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a level change, >= 1
POS_INICIAL, 3, position loaded at reset, < N_POS
PW, $clog2(N_POS), position width (localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
SinalBotao1  input  1  raw button, request move up (+1)
SinalBotao2  input  1  raw button, request move down (-1)
posicao  output  PW  current position, registered
posicao_onehot  output  N_POS  registered, equals 1 << posicao
movimento  output  1  one-cycle strobe: posicao changed this cycle
limite  output  1  one-cycle strobe: accepted request refused at a bound

Behaviour:
- Reset is one clock; asynchronous, active-high. While rst=1:
  - posicao=POS_INICIAL, posicao_onehot=1<<POS_INICIAL.
  - movimento=0, limite=0.
  - Synchroniser flops, debounced levels, previous levels and debounce counters all 0.
- Reset asserted mid-debounce or mid-move: the partial count is discarded, with no move and no strobe.
- Synchroniser: two flops per button. sinc_n follows the input 2 rising edges later.
- Debounce, per button, counter width $clog2(DEBOUNCE_CYCLES+1):
  - If sinc == deb: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= sinc, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A pulse or gap shorter than DEBOUNCE_CYCLES synchronised cycles never changes deb.
- Edge detect:
  - deb_ant <= deb every cycle.
  - Request pulse sobe = deb1 & ~deb1_ant; desce = deb2 & ~deb2_ant.
  - Only rising edges (presses) count. Releases and holding never generate moves; there is no auto-repeat.
- Position update, registered on the cycle the request pulse is high:
  - sobe only, posicao < N_POS-1: posicao+1, movimento=1.
  - sobe only, posicao == N_POS-1: no change, limite=1.
  - desce only, posicao > 0: posicao-1, movimento=1.
  - desce only, posicao == 0: no change, limite=1.
  - sobe and desce in the same cycle: cancel; no change, no strobes.
  - Neither: hold; strobes 0.
- posicao never wraps. Arithmetic is done in PW bits, with the bound checked before the add or subtract.
- Latency:
  - Clean input edge set up before rising edge k: posicao and both strobes update at edge k+DEBOUNCE_CYCLES+2.
  - With the default DEBOUNCE_CYCLES=4, this is the 7th rising edge counting edge k as the 1st.
- movimento and limite are mutually exclusive and each high for exactly 1 cycle per event.
- Button held through reset release: deb rises DEBOUNCE_CYCLES cycles after sinc, producing exactly one move. This is intended.

Decomposition:
- Shared package/header pos_jogo_pkg holds the constants N_POS and POS_INICIAL, reused by the player-1 instance and the display.
- One natural sub-module, debounce_botao, instantiated twice. It contains the synchroniser, counter, deb and deb_ant registers, and outputs the one-cycle pulse.
- The top level holds only the arbitration and the position/one-hot registers.

Test Plan:
1. Reset with defaults -> posicao=3, posicao_onehot=8'b0000_1000, strobes 0. Then a clean press of SinalBotao1 lasting 20 cycles -> posicao=4 exactly at the 7th edge, movimento high 1 cycle, no further change while held.
2. SinalBotao1 glitch high for 2 cycles, plus a bounce train 1-0-1-0 of 1-cycle pulses before a stable 1 -> no change for the glitch. Exactly one increment for the bouncy press, occurring 4 synchronised cycles after the last transition.
3. Five clean presses of SinalBotao1 from 3 -> positions 4,5,6,7. The 5th press gives posicao=7 unchanged, limite=1 for 1 cycle, movimento=0. Mirror with SinalBotao2 down to 0, the last press giving limite.
4. Both buttons pressed on the same cycle at posicao=3 -> posicao stays 3, no strobes. Presses staggered by 10 cycles -> 4, then back to 3, with two movimento pulses.
5. rst asserted asynchronously (between edges) at posicao=6, mid-debounce of SinalBotao2 -> posicao=3 immediately, no strobe. After release with the button still held -> one decrement to 2.
6. Sweep with N_POS=5, DEBOUNCE_CYCLES=1 -> latency is 4 edges. Clamps at 0 and 4, and posicao_onehot always equals 1<<posicao.
